pipe_stage_skid: RTL



---
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a one-entry skid buffer, flush,
// start gating and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Occupancy encoded directly as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_FULL  = 2'b10,
    S_SKID  = 2'b11
  } state_t;

  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_acc;
  logic              w_emit;
  logic              w_stall;
  state_t            w_state;

  // Ready comes only from the skid flag, so upstream never sees a path from
  // out_ready_i. Reset is folded in so the stage refuses entries while held.
  assign in_ready_o = rst_i & start_i & ~r_skid_vld;
  assign w_acc      = in_valid_i & in_ready_o;
  assign w_emit     = r_main_vld & out_ready_i & start_i;
  assign w_stall    = start_i & r_main_vld & ~out_ready_i;
  assign w_state    = state_t'({r_main_vld, r_skid_vld});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (start_i) begin
      if (flush_i) begin
        // Kill both entries; data is left as-is since it is never observed
        // without a valid.
        r_main_vld  <= 1'b0;
        r_main_ctrl <= '0;
        r_skid_vld  <= 1'b0;
        r_skid_ctrl <= '0;
      end else begin
        case (w_state)
          S_EMPTY: begin
            if (w_acc) begin
              r_main_vld  <= 1'b1;
              r_main_ctrl <= ctrl_i;
              r_main_data <= data_i;
            end
          end
          S_FULL: begin
            if (w_emit && w_acc) begin
              r_main_ctrl <= ctrl_i;
              r_main_data <= data_i;
            end else if (w_emit) begin
              r_main_vld  <= 1'b0;
              r_main_ctrl <= '0;
            end else if (w_acc) begin
              r_skid_vld  <= 1'b1;
              r_skid_ctrl <= ctrl_i;
              r_skid_data <= data_i;
            end
          end
          S_SKID: begin
            if (w_emit) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
              r_skid_vld  <= 1'b0;
              r_skid_ctrl <= '0;
            end
          end
          default: begin
            // Skid without main cannot be reached; drop to a clean bubble.
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid_o = r_main_vld;
  assign ctrl_o      = r_main_ctrl;
  assign data_o      = r_main_data;
  assign stall_cnt_o = r_stall_cnt;

endmodule
